// File: rtl/idu_pkg.sv
// Shared decode constants for the IDU immediate stage: opcode map, one-hot
// type bit positions and the default datapath width.
package idu_pkg;

    localparam int XLEN_DEFAULT = 64;
    localparam int TYPE_W       = 6;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;

    // Bit positions inside the one-hot {R,I,S,B,U,J} type vector
    localparam int T_R = 5;
    localparam int T_I = 4;
    localparam int T_S = 3;
    localparam int T_B = 2;
    localparam int T_U = 1;
    localparam int T_J = 0;

endpackage

// File: rtl/idu_imm_gen.sv
// Combinational opcode classifier and AND-OR immediate builder.
// With IDU_ILLEGAL_CHECK_EN defined it also flags malformed/unknown opcodes.
module idu_imm_gen
    import idu_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int INST_W = 32
) (
    input  logic [INST_W-1:0] i_inst,
`ifdef IDU_ILLEGAL_CHECK_EN
    output logic              o_illegal,
`endif
    output logic [TYPE_W-1:0] o_type,
    output logic [XLEN-1:0]   o_imm
);

    logic [6:0]        w_opcode;
    logic [TYPE_W-1:0] w_type;
    logic [XLEN-1:0]   w_imm_i;
    logic [XLEN-1:0]   w_imm_s;
    logic [XLEN-1:0]   w_imm_b;
    logic [XLEN-1:0]   w_imm_u;
    logic [XLEN-1:0]   w_imm_j;

    assign w_opcode = i_inst[6:0];

    always_comb begin
        w_type      = '0;
        w_type[T_R] = (w_opcode == OPC_OP) || (w_opcode == OPC_OP32);
        w_type[T_I] = (w_opcode == OPC_LOAD) || (w_opcode == OPC_OP_IMM) ||
                      (w_opcode == OPC_OP_IMM32) || (w_opcode == OPC_JALR) ||
                      (w_opcode == OPC_SYSTEM);
        w_type[T_S] = (w_opcode == OPC_STORE);
        w_type[T_B] = (w_opcode == OPC_BRANCH);
        w_type[T_U] = (w_opcode == OPC_LUI) || (w_opcode == OPC_AUIPC);
        w_type[T_J] = (w_opcode == OPC_JAL);
    end

    assign w_imm_i = {{(XLEN-12){i_inst[31]}}, i_inst[31:20]};
    assign w_imm_s = {{(XLEN-12){i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
    assign w_imm_b = {{(XLEN-13){i_inst[31]}}, i_inst[31], i_inst[7],
                      i_inst[30:25], i_inst[11:8], 1'b0};
    assign w_imm_u = {{(XLEN-32){i_inst[31]}}, i_inst[31:12], 12'b0};
    assign w_imm_j = {{(XLEN-21){i_inst[31]}}, i_inst[31], i_inst[19:12],
                      i_inst[20], i_inst[30:21], 1'b0};

    // Type is one-hot, so a flat AND-OR mux suffices; R and unknown yield zero
    assign o_imm = ({XLEN{w_type[T_I]}} & w_imm_i) |
                   ({XLEN{w_type[T_S]}} & w_imm_s) |
                   ({XLEN{w_type[T_B]}} & w_imm_b) |
                   ({XLEN{w_type[T_U]}} & w_imm_u) |
                   ({XLEN{w_type[T_J]}} & w_imm_j);

    assign o_type = w_type;

`ifdef IDU_ILLEGAL_CHECK_EN
    assign o_illegal = (i_inst[1:0] != 2'b11) || (w_type == '0);
`endif

endmodule

// File: rtl/idu_imm_stage.sv
// Decode stage: classifies and builds the immediate, then registers the entry
// behind a 2-entry skid buffer. IDU_ILLEGAL_CHECK_EN adds out_illegal.
module idu_imm_stage
    import idu_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    input  logic [XLEN-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [XLEN-1:0]   out_pc,
    output logic [TYPE_W-1:0] out_type,
`ifdef IDU_ILLEGAL_CHECK_EN
    output logic              out_illegal,
`endif
    output logic [XLEN-1:0]   out_imm
);

    logic [TYPE_W-1:0] w_dec_type;
    logic [XLEN-1:0]   w_dec_imm;
    logic              w_fire_in;
    logic              w_fire_out;
    logic              w_main_load;

    logic              r_main_valid;
    logic [INST_W-1:0] r_main_inst;
    logic [XLEN-1:0]   r_main_pc;
    logic [TYPE_W-1:0] r_main_type;
    logic [XLEN-1:0]   r_main_imm;

    logic              r_skid_valid;
    logic [INST_W-1:0] r_skid_inst;
    logic [XLEN-1:0]   r_skid_pc;
    logic [TYPE_W-1:0] r_skid_type;
    logic [XLEN-1:0]   r_skid_imm;

`ifdef IDU_ILLEGAL_CHECK_EN
    logic              w_dec_illegal;
    logic              r_main_illegal;
    logic              r_skid_illegal;
`endif

    idu_imm_gen #(
        .XLEN   (XLEN),
        .INST_W (INST_W)
    ) u_imm_gen (
        .i_inst    (in_inst),
`ifdef IDU_ILLEGAL_CHECK_EN
        .o_illegal (w_dec_illegal),
`endif
        .o_type    (w_dec_type),
        .o_imm     (w_dec_imm)
    );

    // in_ready depends only on the skid flag, never on out_ready
    assign w_fire_in   = in_valid & ~r_skid_valid;
    assign w_fire_out  = r_main_valid & out_ready;
    assign w_main_load = ~r_main_valid | w_fire_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_main_load) begin
            if (r_skid_valid) begin
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_main_valid <= w_fire_in;
            end
        end else if (w_fire_in) begin
            r_skid_valid <= 1'b1;
        end
    end

    // Skid has priority when main refills so program order is kept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_inst <= '0;
            r_main_pc   <= '0;
            r_main_type <= '0;
            r_main_imm  <= '0;
        end else if (w_main_load && r_skid_valid) begin
            r_main_inst <= r_skid_inst;
            r_main_pc   <= r_skid_pc;
            r_main_type <= r_skid_type;
            r_main_imm  <= r_skid_imm;
        end else if (w_main_load && w_fire_in) begin
            r_main_inst <= in_inst;
            r_main_pc   <= in_pc;
            r_main_type <= w_dec_type;
            r_main_imm  <= w_dec_imm;
        end
    end

    always_ff @(posedge clk) begin
        if (!w_main_load && w_fire_in) begin
            r_skid_inst <= in_inst;
            r_skid_pc   <= in_pc;
            r_skid_type <= w_dec_type;
            r_skid_imm  <= w_dec_imm;
        end
    end

`ifdef IDU_ILLEGAL_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_illegal <= 1'b0;
        end else if (w_main_load && r_skid_valid) begin
            r_main_illegal <= r_skid_illegal;
        end else if (w_main_load && w_fire_in) begin
            r_main_illegal <= w_dec_illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (!w_main_load && w_fire_in) begin
            r_skid_illegal <= w_dec_illegal;
        end
    end

    assign out_illegal = r_main_illegal;
`endif

    assign in_ready  = ~r_skid_valid;
    assign out_valid = r_main_valid;
    assign out_inst  = r_main_inst;
    assign out_pc    = r_main_pc;
    assign out_type  = r_main_type;
    assign out_imm   = r_main_imm;

endmodule
